e_mdu_ctrl: RTL and testbench

//   Sequencer for the E-stage multiply/divide unit. Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO

---
 rtl/e_mdu_ctrl.sv | 141 ++++++++++++++
 tb/tb_e_mdu_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: accepts one MDU request, holds busy for a
// fixed latency, then commits the precomputed result to HI/LO.
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             busy_n, done_n;
    logic [31:0]      hi_n, lo_n, pend_hi, pend_hi_n, pend_lo, pend_lo_n;
    logic             pend_wr, pend_wr_n;
    logic             is_mdu, is_div, is_signed;
    logic [63:0]      mul_res, div_res;

    // Full 64-bit product; {hi, lo} layout.
    function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        logic signed [63:0] sa, sb;
        logic        [63:0] ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (sgn) mul_full = sa * sb;
        else     mul_full = ua * ub;
    endfunction

    // Magnitude division keeps INT_MIN / -1 a plain wrap; returns {remainder, quotient}.
    function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        logic        na, nb;
        logic [31:0] ma, mb, q, r;
        na = sgn & a[31];
        nb = sgn & b[31];
        ma = na ? (~a + 32'd1) : a;
        mb = nb ? (~b + 32'd1) : b;
        q  = (mb == 32'd0) ? 32'd0 : ma / mb;
        r  = (mb == 32'd0) ? 32'd0 : ma % mb;
        if (na ^ nb) q = ~q + 32'd1;
        if (na)      r = ~r + 32'd1;
        div_full = {r, q};
    endfunction

    assign is_mdu    = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign mul_res   = mul_full(rs_val, rt_val, is_signed);
    assign div_res   = div_full(rs_val, rt_val, is_signed);
    assign stall_req = busy | (start & is_mdu);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            busy    <= busy_n;
            done    <= done_n;
            hi      <= hi_n;
            lo      <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            pend_wr <= pend_wr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        busy_n    = busy;
        done_n    = 1'b0;
        hi_n      = hi;
        lo_n      = lo;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        pend_wr_n = pend_wr;
        case (state)
            IDLE: begin
                if (start && is_mdu) begin
                    {pend_hi_n, pend_lo_n} = is_div ? div_res : mul_res;
                    // A zero divisor still occupies the unit but leaves HI/LO untouched.
                    pend_wr_n = !(is_div && (rt_val == 32'd0));
                    cnt_n     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    busy_n    = 1'b1;
                    state_n   = BUSY;
                end else if (start && (op == OP_MTHI)) begin
                    hi_n = rs_val;
                end else if (start && (op == OP_MTLO)) begin
                    lo_n = rs_val;
                end
            end
            BUSY: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    if (pend_wr) begin
                        hi_n = pend_hi;
                        lo_n = pend_lo;
                    end
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: vector table plus hand sequences, with a
// scoreboard of expected commits compared whenever done pulses.
module tb_e_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;

    e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy),
        .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;
    int   busy_run = 0;
    logic [31:0] saved_lo;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and sample on the falling edge; done pulses are scored here.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check32("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check32("commit_hi", hi, e.hi);
                    check32("commit_lo", lo, e.lo);
                    check32("busy_cycles", 32'(busy_run), 32'(e.cyc));
                    busy_run = 0;
                end
            end
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int cyc);
        exp_t e;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        #1;
        if (o >= 3'd1 && o <= 3'd4) begin
            e.hi = eh; e.lo = el; e.cyc = cyc;
            sb_q.push_back(e);
            check32("stall_req_mdu", 32'(stall_req), 32'd1);
        end else begin
            check32("stall_req_mt", 32'(stall_req), 32'(busy));
        end
        tick();
        start = 1'b0;
        op    = 3'd0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
        if (sb_q.size() != 0) begin
            check32("done_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        tick();
        check32("done_single", 32'(done), 32'd0);
        check32("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
        vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[6] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[7] = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};

        reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
        tick();
        tick();
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check32("reset_busy", 32'(busy), 32'd0);
        check32("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cyc);
            check32("busy_after_accept", 32'(busy), 32'd1);
            wait_done();
        end

        // MTHI while idle updates HI on the next edge without busy or done.
        saved_lo = lo;
        issue(3'd5, 32'h12345678, 32'd0, 32'd0, 32'd0, 0);
        check32("mthi_hi", hi, 32'h12345678);
        check32("mthi_lo_kept", lo, saved_lo);
        check32("mthi_busy", 32'(busy), 32'd0);
        check32("mthi_done", 32'(done), 32'd0);

        // MTLO issued during a multiply is ignored.
        issue(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        saved_lo = lo;
        issue(3'd6, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 0);
        check32("mtlo_busy_ignored", lo, saved_lo);
        wait_done();

        // Divide by zero runs the full latency and leaves HI/LO alone.
        issue(3'd5, 32'h000000AA, 32'd0, 32'd0, 32'd0, 0);
        issue(3'd6, 32'h00000055, 32'd0, 32'd0, 32'd0, 0);
        check32("mtlo_idle", lo, 32'h00000055);
        issue(3'd3, 32'd5, 32'd0, 32'h000000AA, 32'h00000055, 10);
        wait_done();

        // Reset in the middle of a divide discards the result.
        issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        busy_run = 0;
        check32("midreset_busy", 32'(busy), 32'd0);
        check32("midreset_hi", hi, 32'd0);
        check32("midreset_lo", lo, 32'd0);
        check32("midreset_done", 32'(done), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check32("midreset_quiet_lo", lo, 32'd0);
        issue(3'd2, 32'd6, 32'd7, 32'd0, 32'd42, 5);
        check32("post_reset_accept", 32'(busy), 32'd1);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
